// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg
//   EX/MEM pipeline register for the five-stage CPU. It captures the EX-stage
//   result and control bits on every rising clk edge, tracks whether the
//   stored entry is a real instruction, supports hold (stall) and
//   bubble insertion (flush), squashes control bits of bubbles, reports
//   EX/MEM-to-EX forwarding hits for two source operands and keeps
//   saturating stall/flush event counters for debug.
//
// Parameters
//   DATA_W   width of ALU result, constant and store-data fields
//   REG_AW   register-address width
//   CNT_W    width of each event counter
//   ZERO_REG when 1, register 0 never produces a forwarding hit
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   stall, flush                  hold / bubble-insert requests
//   nvalid, nWBregwr, nWBregomem,
//   nMEMwr, nALUout, nconstant,
//   nreadDATA2, nwriteREG         incoming EX-stage entry
//   rsA, rsB                      source registers of the instruction in EX
//   valid, WBregwr, WBregomem,
//   MEMwr, ALUout, constant,
//   readDATA2, writeREG           stored entry
//   fwdA, fwdB                    forwarding hits (combinational)
//   stall_cnt, flush_cnt          saturating event counters
module ex_mem_stage_reg #(
  parameter int DATA_W   = 8,
  parameter int REG_AW   = 3,
  parameter int CNT_W    = 16,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              nvalid,
  input  logic              nWBregwr,
  input  logic              nWBregomem,
  input  logic              nMEMwr,
  input  logic [DATA_W-1:0] nALUout,
  input  logic [DATA_W-1:0] nconstant,
  input  logic [DATA_W-1:0] nreadDATA2,
  input  logic [REG_AW-1:0] nwriteREG,
  input  logic [REG_AW-1:0] rsA,
  input  logic [REG_AW-1:0] rsB,
  output logic              valid,
  output logic              WBregwr,
  output logic              WBregomem,
  output logic              MEMwr,
  output logic [DATA_W-1:0] ALUout,
  output logic [DATA_W-1:0] constant,
  output logic [DATA_W-1:0] readDATA2,
  output logic [REG_AW-1:0] writeREG,
  output logic              fwdA,
  output logic              fwdB,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [REG_AW-1:0] REG_ZERO  = {REG_AW{1'b0}};

  logic              valid_q,     valid_d;
  logic              wbregwr_q,   wbregwr_d;
  logic              wbregomem_q, wbregomem_d;
  logic              memwr_q,     memwr_d;
  logic [DATA_W-1:0] aluout_q,    aluout_d;
  logic [DATA_W-1:0] constant_q,  constant_d;
  logic [DATA_W-1:0] readdata2_q, readdata2_d;
  logic [REG_AW-1:0] writereg_q,  writereg_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  // Hit test for one source operand against the stored entry. Loads
  // (WBregomem) are left to the hazard unit and never forward from here.
  function automatic logic fwd_hit(
    input logic              v,
    input logic              wr,
    input logic              omem,
    input logic [REG_AW-1:0] dst,
    input logic [REG_AW-1:0] rs
  );
    logic zero_block;
    zero_block = ZERO_REG && (rs == REG_ZERO);
    return v & wr & ~omem & (dst == rs) & ~zero_block;
  endfunction

  // Next entry: flush beats stall, stall holds, otherwise load with bubble squash.
  always_comb begin
    valid_d     = valid_q;
    wbregwr_d   = wbregwr_q;
    wbregomem_d = wbregomem_q;
    memwr_d     = memwr_q;
    aluout_d    = aluout_q;
    constant_d  = constant_q;
    readdata2_d = readdata2_q;
    writereg_d  = writereg_q;
    if (flush) begin
      valid_d     = 1'b0;
      wbregwr_d   = 1'b0;
      wbregomem_d = 1'b0;
      memwr_d     = 1'b0;
      aluout_d    = DATA_ZERO;
      constant_d  = DATA_ZERO;
      readdata2_d = DATA_ZERO;
      writereg_d  = REG_ZERO;
    end else if (stall) begin
      valid_d     = valid_q;
      wbregwr_d   = wbregwr_q;
      wbregomem_d = wbregomem_q;
      memwr_d     = memwr_q;
    end else begin
      // Data is captured even for bubbles; only the control bits are squashed
      // so that valid=0 always implies no side effects downstream.
      valid_d     = nvalid;
      wbregwr_d   = nvalid & nWBregwr;
      wbregomem_d = nvalid & nWBregomem;
      memwr_d     = nvalid & nMEMwr;
      aluout_d    = nALUout;
      constant_d  = nconstant;
      readdata2_d = nreadDATA2;
      writereg_d  = nwriteREG;
    end
  end

  // Saturating event counters; stall and flush count independently.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      wbregwr_q   <= 1'b0;
      wbregomem_q <= 1'b0;
      memwr_q     <= 1'b0;
      aluout_q    <= DATA_ZERO;
      constant_q  <= DATA_ZERO;
      readdata2_q <= DATA_ZERO;
      writereg_q  <= REG_ZERO;
      stall_cnt_q <= CNT_ZERO;
      flush_cnt_q <= CNT_ZERO;
    end else begin
      valid_q     <= valid_d;
      wbregwr_q   <= wbregwr_d;
      wbregomem_q <= wbregomem_d;
      memwr_q     <= memwr_d;
      aluout_q    <= aluout_d;
      constant_q  <= constant_d;
      readdata2_q <= readdata2_d;
      writereg_q  <= writereg_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign valid     = valid_q;
  assign WBregwr   = wbregwr_q;
  assign WBregomem = wbregomem_q;
  assign MEMwr     = memwr_q;
  assign ALUout    = aluout_q;
  assign constant  = constant_q;
  assign readDATA2 = readdata2_q;
  assign writeREG  = writereg_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Forwarding depends only on stored state and the current source registers.
  assign fwdA = fwd_hit(valid_q, wbregwr_q, wbregomem_q, writereg_q, rsA);
  assign fwdB = fwd_hit(valid_q, wbregwr_q, wbregomem_q, writereg_q, rsB);

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Scoreboard bench for ex_mem_stage_reg. Two instances share the stimulus:
// u_dut0 uses the default parameters, u_dut1 uses CNT_W=3 and ZERO_REG=0 so
// counter saturation and register-0 forwarding are reachable quickly.
module tb_ex_mem_stage_reg;

  typedef struct packed {
    logic       rst, stall, flush, nvalid, nwr, nomem, nmemwr;
    logic [7:0] alu, cst, rd2;
    logic [2:0] wreg, rsa, rsb;
  } in_t;

  typedef struct packed {
    logic       valid, wr, omem, memwr;
    logic [7:0] alu, cst, rd2;
    logic [2:0] wreg;
    int         scnt, fcnt;
  } st_t;

  typedef struct packed {
    logic        valid, wr, omem, memwr;
    logic [7:0]  alu, cst, rd2;
    logic [2:0]  wreg;
    logic        fa, fb;
    logic [15:0] sc, fc;
  } obs_t;

  typedef struct packed {
    obs_t e0;
    obs_t e1;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t d;   // applied to the DUTs
  in_t s;   // staged by the sequencer for the next cycle
  st_t m0, m1;
  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic       v0, wr0, om0, mw0, fa0, fb0;
  logic [7:0] alu0, cst0, rd0;
  logic [2:0] wreg0;
  logic [15:0] sc0, fc0;
  logic       v1, wr1, om1, mw1, fa1, fb1;
  logic [7:0] alu1, cst1, rd1;
  logic [2:0] wreg1;
  logic [2:0] sc1, fc1;

  ex_mem_stage_reg #(.DATA_W(8), .REG_AW(3), .CNT_W(16), .ZERO_REG(1'b1)) u_dut0 (
    .clk(clk), .rst(d.rst), .stall(d.stall), .flush(d.flush), .nvalid(d.nvalid),
    .nWBregwr(d.nwr), .nWBregomem(d.nomem), .nMEMwr(d.nmemwr),
    .nALUout(d.alu), .nconstant(d.cst), .nreadDATA2(d.rd2), .nwriteREG(d.wreg),
    .rsA(d.rsa), .rsB(d.rsb),
    .valid(v0), .WBregwr(wr0), .WBregomem(om0), .MEMwr(mw0),
    .ALUout(alu0), .constant(cst0), .readDATA2(rd0), .writeREG(wreg0),
    .fwdA(fa0), .fwdB(fb0), .stall_cnt(sc0), .flush_cnt(fc0));

  ex_mem_stage_reg #(.DATA_W(8), .REG_AW(3), .CNT_W(3), .ZERO_REG(1'b0)) u_dut1 (
    .clk(clk), .rst(d.rst), .stall(d.stall), .flush(d.flush), .nvalid(d.nvalid),
    .nWBregwr(d.nwr), .nWBregomem(d.nomem), .nMEMwr(d.nmemwr),
    .nALUout(d.alu), .nconstant(d.cst), .nreadDATA2(d.rd2), .nwriteREG(d.wreg),
    .rsA(d.rsa), .rsB(d.rsb),
    .valid(v1), .WBregwr(wr1), .WBregomem(om1), .MEMwr(mw1),
    .ALUout(alu1), .constant(cst1), .readDATA2(rd1), .writeREG(wreg1),
    .fwdA(fa1), .fwdB(fb1), .stall_cnt(sc1), .flush_cnt(fc1));

  // Reference model: one edge of the pipeline register in plain terms.
  function automatic st_t model_step(st_t m, in_t i, int cmax);
    st_t n;
    n = m;
    if (i.rst) begin
      n = '0;
    end else begin
      if (i.stall) n.scnt = (m.scnt < cmax) ? m.scnt + 1 : cmax;
      if (i.flush) n.fcnt = (m.fcnt < cmax) ? m.fcnt + 1 : cmax;
      if (i.flush) begin
        n.valid = 1'b0; n.wr = 1'b0; n.omem = 1'b0; n.memwr = 1'b0;
        n.alu = 8'h00; n.cst = 8'h00; n.rd2 = 8'h00; n.wreg = 3'd0;
      end else if (!i.stall) begin
        n.valid = i.nvalid;
        n.wr    = i.nvalid ? i.nwr    : 1'b0;
        n.omem  = i.nvalid ? i.nomem  : 1'b0;
        n.memwr = i.nvalid ? i.nmemwr : 1'b0;
        n.alu = i.alu; n.cst = i.cst; n.rd2 = i.rd2; n.wreg = i.wreg;
      end
    end
    return n;
  endfunction

  function automatic logic model_fwd(st_t m, logic [2:0] rs, bit zr);
    if (zr && rs == 3'd0) return 1'b0;
    return m.valid && m.wr && !m.omem && (m.wreg == rs);
  endfunction

  function automatic obs_t to_obs(st_t m, in_t i, bit zr);
    obs_t o;
    o.valid = m.valid; o.wr = m.wr; o.omem = m.omem; o.memwr = m.memwr;
    o.alu = m.alu; o.cst = m.cst; o.rd2 = m.rd2; o.wreg = m.wreg;
    o.fa = model_fwd(m, i.rsa, zr);
    o.fb = model_fwd(m, i.rsb, zr);
    o.sc = 16'(m.scnt);
    o.fc = 16'(m.fcnt);
    return o;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: apply staged inputs, let the edge happen, push the expectation.
  task automatic cycle();
    @(negedge clk);
    #1;
    d = s;
    @(posedge clk);
    m0 = model_step(m0, d, 65535);
    m1 = model_step(m1, d, 7);
    q.push_back('{e0: to_obs(m0, d, 1'b1), e1: to_obs(m1, d, 1'b0)});
    #1;
  endtask

  // Monitor: compare every registered/forwarded output once per cycle.
  initial begin
    obs_t a0, a1;
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        a0 = '{v0, wr0, om0, mw0, alu0, cst0, rd0, wreg0, fa0, fb0, sc0, fc0};
        a1 = '{v1, wr1, om1, mw1, alu1, cst1, rd1, wreg1, fa1, fb1,
               {13'd0, sc1}, {13'd0, fc1}};
        n_tests++;
        if (a0 !== e.e0) begin
          n_fail++;
          $display("FAIL out0 @%0t: got %h expected %h", $time, a0, e.e0);
        end
        n_tests++;
        if (a1 !== e.e1) begin
          n_fail++;
          $display("FAIL out1 @%0t: got %h expected %h", $time, a1, e.e1);
        end
      end
    end
  end

  task automatic stage_load(input logic nv, input logic wr, input logic om,
                            input logic mw, input logic [7:0] alu,
                            input logic [2:0] wreg);
    s = '0;
    s.nvalid = nv; s.nwr = wr; s.nomem = om; s.nmemwr = mw;
    s.alu = alu; s.cst = 8'h3C; s.rd2 = 8'hC3; s.wreg = wreg;
    s.rsa = d.rsa; s.rsb = d.rsb;
  endtask

  initial begin
    m0 = '0; m1 = '0;
    d = '0; d.rst = 1'b1;

    // Reset with every incoming bit high.
    s = '1;
    cycle(); cycle();
    check("rst_valid", v0, 0);
    check("rst_alu", alu0, 0);
    check("rst_cnt", sc0 + fc0, 0);
    check("rst_fwd", fa0 | fb0, 0);

    // Load and forward.
    stage_load(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 3'd3);
    s.rsa = 3'd3; s.rsb = 3'd0;
    cycle();
    check("ld_alu", alu0, 8'h5A);
    check("ld_valid", v0, 1);
    check("ld_fwdA", fa0, 1);
    check("ld_fwdB", fb0, 0);

    // Register 0 forwarding depends on ZERO_REG.
    stage_load(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 3'd0);
    s.rsa = 3'd3; s.rsb = 3'd0;
    cycle();
    check("zr1_fwdB", fb0, 0);
    check("zr0_fwdB", fb1, 1);

    // Stall hold for three edges.
    stage_load(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 3'd3);
    cycle();
    stage_load(1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 3'd4);
    s.stall = 1'b1;
    cycle(); cycle(); cycle();
    check("stall_alu", alu0, 8'h5A);
    check("stall_cnt", sc0, 3);
    s.stall = 1'b0;
    cycle();
    check("unstall_alu", alu0, 8'h11);

    // Flush beats stall on a valid store.
    stage_load(1'b1, 1'b0, 1'b0, 1'b1, 8'h77, 3'd5);
    cycle();
    check("store_memwr", mw0, 1);
    s.stall = 1'b1; s.flush = 1'b1;
    cycle();
    check("fl_valid", v0, 0);
    check("fl_memwr", mw0, 0);
    check("fl_alu", alu0, 0);
    check("fl_scnt", sc0, 4);
    check("fl_fcnt", fc0, 1);

    // Bubble squash, then a load that must not forward.
    stage_load(1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 3'd3);
    s.rsa = 3'd3;
    cycle();
    check("sq_valid", v0, 0);
    check("sq_memwr", mw0, 0);
    check("sq_alu", alu0, 8'h22);
    check("sq_fwdA", fa0, 0);
    stage_load(1'b1, 1'b1, 1'b1, 1'b0, 8'h44, 3'd3);
    s.rsa = 3'd3;
    cycle();
    check("ldm_fwdA", fa0, 0);

    // Saturation of the 3-bit counter.
    s = '0; s.rst = 1'b1;
    cycle();
    s.rst = 1'b0; s.stall = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      check("sat_cnt", sc1, (k < 7) ? k : 7);
    end

    // Randomised traffic.
    for (int k = 0; k < 600; k++) begin
      s.rst    = ($urandom_range(0, 49) == 0);
      s.flush  = ($urandom_range(0, 9) == 0);
      s.stall  = ($urandom_range(0, 3) == 0);
      s.nvalid = ($urandom_range(0, 3) != 0);
      s.nwr    = 1'($urandom);
      s.nomem  = 1'($urandom);
      s.nmemwr = 1'($urandom);
      s.alu    = 8'($urandom);
      s.cst    = 8'($urandom);
      s.rd2    = 8'($urandom);
      s.wreg   = 3'($urandom);
      s.rsa    = 3'($urandom);
      s.rsb    = 3'($urandom);
      cycle();
    end

    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
